// File: rtl/mips_isa.sv
// Shared MIPS ISA definitions: sequencer states, ALU op codes, datapath mux
// encodings and opcode class decoding used by control and decode logic.
package mips_isa;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;  // shift / compare
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOR  = 3'b110;
    localparam logic [2:0] ALU_NONE = 3'b111;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] SRC_B_RT       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_ALU_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t op_class(input logic [5:0] opcode);
        op_class_t cls;
        casez (opcode)
            6'b000000: cls = CLS_RTYPE;
            6'b00001?: cls = CLS_JUMP;
            6'b0001??: cls = CLS_BRANCH;
            6'b001???: cls = CLS_ALU_IMM;
            6'b100???: cls = CLS_LOAD;
            6'b101???: cls = CLS_STORE;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic is_jr(input logic [5:0] funct);
        return funct[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation select for the EXEC step, derived from the
// instruction register opcode and funct fields.
module alu_op_decode
    import mips_isa::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path can infer a latch.
        alu_op = ALU_NONE;
        case (op_class(opcode))
            CLS_RTYPE: begin
                casez (funct)
                    6'b10000?:         alu_op = ALU_ADD;
                    6'b10001?:         alu_op = ALU_SUB;
                    6'b000???,
                    6'b1010??:         alu_op = ALU_SLT;
                    6'b100100:         alu_op = ALU_AND;
                    6'b100101:         alu_op = ALU_OR;
                    6'b100110:         alu_op = ALU_XOR;
                    6'b100111:         alu_op = ALU_NOR;
                    default:           alu_op = ALU_NONE;
                endcase
            end
            CLS_ALU_IMM: begin
                casez (opcode[2:0])
                    3'b00?:  alu_op = ALU_ADD;
                    3'b01?:  alu_op = ALU_SLT;
                    3'b100:  alu_op = ALU_AND;
                    3'b101:  alu_op = ALU_OR;
                    3'b110:  alu_op = ALU_XOR;
                    default: alu_op = ALU_SLT;  // lui goes through the shifter
                endcase
            end
            CLS_BRANCH:           alu_op = ALU_SUB;
            CLS_LOAD, CLS_STORE:  alu_op = ALU_ADD;
            default:              alu_op = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: Moore FSM stepping FETCH/DECODE/EXEC/MEM/WB with
// a ready handshake on the shared memory port, illegal-opcode and timeout flags.
module multicycle_control
    import mips_isa::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic       illegal,
    output logic       bus_error
);

    state_t    state, state_next;
    logic [7:0] wait_cnt;
    op_class_t cls;
    logic [2:0] exec_alu_op;
    logic       waiting;
    logic       wait_expired;

    assign cls          = op_class(opcode);
    assign waiting      = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
    assign wait_expired = waiting && ((wait_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

    alu_op_decode u_alu_op_decode (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (exec_alu_op)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 8'd0;
            bus_error <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= 8'd0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_expired) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_op     = ALU_NONE;
        retire     = 1'b0;
        illegal    = 1'b0;

        case (state)
            ST_IDLE: begin
                alu_op     = ALU_ADD;  // every output reads zero coming out of reset
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SHL2;
                alu_op    = ALU_ADD;
                if (cls == CLS_ILLEGAL) begin
                    illegal    = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_RTYPE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_RT;
                        alu_op    = exec_alu_op;
                        if (is_jr(funct)) begin
                            pc_write   = 1'b1;
                            pc_src     = PC_SRC_REG;
                            retire     = 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            state_next = ST_WB;
                        end
                    end
                    CLS_ALU_IMM: begin
                        alu_src_a  = 1'b1;  // immediate forms operate on rs
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = exec_alu_op;
                        state_next = ST_WB;
                    end
                    CLS_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_RT;
                        alu_op    = exec_alu_op;
                        // beq/bne family: taken when zero differs from opcode[0]
                        if (zero != opcode[0]) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BRANCH;
                        end
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = exec_alu_op;
                        state_next = ST_MEM;
                    end
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls != CLS_LOAD);
                if (mem_ready) begin
                    if (cls == CLS_LOAD) begin
                        state_next = ST_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (wait_expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls == CLS_RTYPE);
                mem2reg    = (cls == CLS_LOAD);
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default-timeout instance for the
// instruction flows, a TIMEOUT_CYCLES=3 instance for the bus-error cases.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem2reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       retire;
        logic       illegal;
        logic       bus_error;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n, rst_n_t3;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;

    logic       mem_read_a, mem_write_a, iord_a, ir_write_a, pc_write_a;
    logic [1:0] pc_src_a, alu_src_b_a;
    logic       reg_write_a, reg_dst_a, mem2reg_a, alu_src_a_a;
    logic [2:0] alu_op_a;
    logic       retire_a, illegal_a, bus_error_a;

    logic       mem_read_b, mem_write_b, iord_b, ir_write_b, pc_write_b;
    logic [1:0] pc_src_b, alu_src_b_b;
    logic       reg_write_b, reg_dst_b, mem2reg_b, alu_src_a_b;
    logic [2:0] alu_op_b;
    logic       retire_b, illegal_b, bus_error_b;

    ctl_t obs_a, obs_b, e;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .iord(iord_a), .ir_write(ir_write_a), .pc_write(pc_write_a), .pc_src(pc_src_a),
        .reg_write(reg_write_a), .reg_dst(reg_dst_a), .mem2reg(mem2reg_a),
        .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a),
        .retire(retire_a), .illegal(illegal_a), .bus_error(bus_error_a)
    );

    multicycle_control #(.TIMEOUT_CYCLES(3)) dut_t3 (
        .clk(clk), .rst_n(rst_n_t3), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .iord(iord_b), .ir_write(ir_write_b), .pc_write(pc_write_b), .pc_src(pc_src_b),
        .reg_write(reg_write_b), .reg_dst(reg_dst_b), .mem2reg(mem2reg_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .retire(retire_b), .illegal(illegal_b), .bus_error(bus_error_b)
    );

    assign obs_a = {mem_read_a, mem_write_a, iord_a, ir_write_a, pc_write_a, pc_src_a,
                    reg_write_a, reg_dst_a, mem2reg_a, alu_src_a_a, alu_src_b_a, alu_op_a,
                    retire_a, illegal_a, bus_error_a};
    assign obs_b = {mem_read_b, mem_write_b, iord_b, ir_write_b, pc_write_b, pc_src_b,
                    reg_write_b, reg_dst_b, mem2reg_b, alu_src_a_b, alu_src_b_b, alu_op_b,
                    retire_b, illegal_b, bus_error_b};

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    // Enter the next cycle, apply this cycle's inputs, let outputs settle.
    task automatic cyc(input logic rdy, input logic z);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    function automatic ctl_t idle_e();
        ctl_t r;
        r = '0;
        return r;
    endfunction

    function automatic ctl_t base_e();
        ctl_t r;
        r = '0;
        r.alu_op = 3'b111;
        return r;
    endfunction

    function automatic ctl_t fetch_e(input logic done);
        ctl_t r;
        r = base_e();
        r.mem_read  = 1'b1;
        r.alu_src_b = 2'b01;
        r.alu_op    = 3'b000;
        r.ir_write  = done;
        r.pc_write  = done;
        return r;
    endfunction

    function automatic ctl_t decode_e(input logic ill);
        ctl_t r;
        r = base_e();
        r.alu_src_b = 2'b11;
        r.alu_op    = 3'b000;
        r.illegal   = ill;
        return r;
    endfunction

    function automatic ctl_t mem_e(input logic is_load);
        ctl_t r;
        r = base_e();
        r.iord      = 1'b1;
        r.mem_read  = is_load;
        r.mem_write = !is_load;
        return r;
    endfunction

    function automatic ctl_t addr_e();
        ctl_t r;
        r = base_e();
        r.alu_src_a = 1'b1;
        r.alu_src_b = 2'b10;
        r.alu_op    = 3'b000;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst_n_t3 = 1'b0;
        opcode = 6'b000000; funct = 6'b100000;
        zero = 1'b0; mem_ready = 1'b0;
        #3;
        check("reset_a", obs_a, idle_e());
        check("reset_b", obs_b, idle_e());
        #9 rst_n = 1'b1;
        #1 check("idle", obs_a, idle_e());

        // add, mem_ready held high: retire in the 4th cycle after IDLE
        cyc(1, 0); check("add_fetch", obs_a, fetch_e(1));
        cyc(1, 0); check("add_decode", obs_a, decode_e(0));
        cyc(1, 0);
        e = base_e(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b000;
        check("add_exec", obs_a, e);
        cyc(1, 0);
        e = base_e(); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
        check("add_wb", obs_a, e);

        // lw with three MEM wait cycles
        cyc(1, 0); opcode = 6'b100011; check("lw_fetch", obs_a, fetch_e(1));
        cyc(1, 0); check("lw_decode", obs_a, decode_e(0));
        cyc(1, 0); check("lw_exec", obs_a, addr_e());
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 0);
            check($sformatf("lw_mem%0d", i), obs_a, mem_e(1));
        end
        cyc(1, 0);
        e = base_e(); e.reg_write = 1'b1; e.mem2reg = 1'b1; e.retire = 1'b1;
        check("lw_wb", obs_a, e);

        // beq with zero=1: taken
        cyc(1, 0); opcode = 6'b000100; check("beq_fetch", obs_a, fetch_e(1));
        cyc(1, 1); check("beq_decode", obs_a, decode_e(0));
        cyc(1, 1);
        e = base_e(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b001;
        e.pc_write = 1'b1; e.pc_src = 2'b01; e.retire = 1'b1;
        check("beq_exec", obs_a, e);

        // bne with zero=1: not taken, one FETCH wait first
        cyc(0, 0); opcode = 6'b000101; check("bne_fetch_wait", obs_a, fetch_e(0));
        cyc(1, 0); check("bne_fetch", obs_a, fetch_e(1));
        cyc(1, 1); check("bne_decode", obs_a, decode_e(0));
        cyc(1, 1);
        e = base_e(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b001;
        e.retire = 1'b1;
        check("bne_exec", obs_a, e);

        // ori: I-type logic, writes rt
        cyc(1, 0); opcode = 6'b001101; check("ori_fetch", obs_a, fetch_e(1));
        cyc(1, 0); check("ori_decode", obs_a, decode_e(0));
        cyc(1, 0);
        e = addr_e(); e.alu_op = 3'b100;
        check("ori_exec", obs_a, e);
        cyc(1, 0);
        e = base_e(); e.reg_write = 1'b1; e.retire = 1'b1;
        check("ori_wb", obs_a, e);

        // j
        cyc(1, 0); opcode = 6'b000010; check("j_fetch", obs_a, fetch_e(1));
        cyc(1, 0); check("j_decode", obs_a, decode_e(0));
        cyc(1, 0);
        e = base_e(); e.pc_write = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
        check("j_exec", obs_a, e);

        // illegal opcode: pulse in DECODE, straight back to FETCH
        cyc(1, 0); opcode = 6'b111111; check("ill_fetch", obs_a, fetch_e(1));
        cyc(1, 0); check("ill_decode", obs_a, decode_e(1));
        cyc(1, 0); opcode = 6'b101011; check("ill_refetch", obs_a, fetch_e(1));

        // sw interrupted by reset in MEM
        cyc(1, 0); check("sw_decode", obs_a, decode_e(0));
        cyc(1, 0); check("sw_exec", obs_a, addr_e());
        cyc(0, 0); check("sw_mem", obs_a, mem_e(0));
        #2 rst_n = 1'b0;
        #1 check("sw_async_reset", obs_a, idle_e());
        #3 rst_n = 1'b1;
        #1 check("restart_idle", obs_a, idle_e());
        cyc(0, 0); check("restart_fetch", obs_a, fetch_e(0));

        // TIMEOUT_CYCLES=3 instance: completion on the limit cycle wins
        rst_n = 1'b0;
        rst_n_t3 = 1'b1;
        #1 check("t3_idle", obs_b, idle_e());
        cyc(1, 0); check("t3_fetch", obs_b, fetch_e(1));
        cyc(1, 0); check("t3_decode", obs_b, decode_e(0));
        cyc(1, 0); check("t3_exec", obs_b, addr_e());
        cyc(0, 0); check("t3_mem0", obs_b, mem_e(0));
        cyc(0, 0); check("t3_mem1", obs_b, mem_e(0));
        cyc(1, 0);
        e = mem_e(0); e.retire = 1'b1;
        check("t3_mem_limit_done", obs_b, e);
        cyc(1, 0); check("t3_fetch2", obs_b, fetch_e(1));

        // sw with mem_ready stuck low: three MEM cycles then HALT with bus_error
        cyc(1, 0); check("t3_decode2", obs_b, decode_e(0));
        cyc(1, 0); check("t3_exec2", obs_b, addr_e());
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0);
            check($sformatf("t3_stuck%0d", i), obs_b, mem_e(0));
        end
        e = base_e(); e.bus_error = 1'b1;
        cyc(0, 0); check("t3_halt0", obs_b, e);
        cyc(1, 0); check("t3_halt1", obs_b, e);
        cyc(1, 0); check("t3_halt2", obs_b, e);
        rst_n_t3 = 1'b0;
        #1 check("t3_reset_clears", obs_b, idle_e());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
